multi_edge_detector: RTL and testbench
======================================

// Module: multi_edge_detector
// PURPOSE
//  Parametrised multi-channel edge detector for asynchronous inputs. Each channel has a
//  synchroniser chain, a debounce filter, and rise/fall/both/off mode selection.
//  Each channel also keeps a sticky event flag and a saturating event counter.
//  Sits between raw pins/async status lines and control logic needing clean 1-cycle events.
// PARAMETERS
//  WIDTH        8  number of channels (1..32)
//  SYNC_STAGES  2  synchroniser flops per channel (2..4)
//  DEB_CYCLES   4  cycles a new synced level must persist before acceptance (1 = no filtering)
//  CNT_W        8  width of each per-channel event counter
// PORTS
//  clk      in   1               rising-edge clock
//  rst_n    in   1               asynchronous, active-low reset
//  d        in   WIDTH           raw async inputs
//  mode     in   2*WIDTH         per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//  det      out  WIDTH           registered 1-cycle event pulse, masked by mode
//  rise     out  WIDTH           registered 1-cycle rising pulse, unmasked
//  fall     out  WIDTH           registered 1-cycle falling pulse, unmasked
//  sticky   out  WIDTH           latched event flag per channel
//  clr      in   WIDTH           per-channel sticky clear, synchronous
//  cnt_clr  in   1               clears all counters, synchronous
//  cnt_sel  in   $clog2(WIDTH)   (min 1) counter select
//  cnt_out  out  CNT_W           counter[cnt_sel], combinational mux of registered counters
// BEHAVIOUR
//  Reset (rst_n=0, immediate): the following registers are 0:
//   - sync chains, filtered level f, debounce counters dc
//   - rise, fall, det, sticky, all counters
//  - cnt_out therefore reads 0 during reset.
//  Sync: s[i] = d[i] delayed through SYNC_STAGES flops.
//  Filter, per channel, each edge:
//   - if s==f: dc<=0.
//   - else if dc==DEB_CYCLES-1: f<=s, dc<=0.
//   - else: dc<=dc+1.
//   - dc width is $clog2(DEB_CYCLES)+1.
//   - A glitch shorter than DEB_CYCLES synced cycles resets dc and produces no event.
//  Edge generation, same edge as f update:
//   - rise <= (f_next & ~f); fall <= (~f_next & f).
//   - det <= (rise_next & mode[2i]) | (fall_next & mode[2i+1]).
//   - All three are high for exactly one cycle per accepted transition.
//  Latency: a level held on d is first sampled at edge E1. The pulse is asserted after edge
//   E(SYNC_STAGES+DEB_CYCLES). Default: after the 6th edge.
//   With SYNC_STAGES=2 and DEB_CYCLES=1: after the 3rd edge.
//  Mode:
//   - Mode may change at any time and never creates an event by itself.
//   - f is tracked regardless of mode.
//   - Mode is sampled on the edge that registers det.
//  Sticky: set when det_next is 1, else cleared by clr[i]. Simultaneous set and clr: set wins.
//  Counter, per channel:
//   - Increments on each det pulse; saturates at 2^CNT_W-1 (no wrap).
//   - cnt_clr with a simultaneous det_next gives count 1 (event not lost).
//   - cnt_clr with no det gives 0.
//  cnt_sel >= WIDTH: cnt_out=0.
//  Reset mid-operation: all state is lost; no pulse on assertion.
//   If d=1 when rst_n releases, one rising event is reported after normal latency,
//   because f restarts at 0.
//  Back-to-back transitions: every transition that survives the filter produces its own
//   pulse; the minimum spacing between pulses is DEB_CYCLES cycles.
// TESTING  (20 ns clock, defaults unless stated)
//  1. Ch0 mode=01; d[0] 0->1, held 10 cycles, then ->0.
//     -> rise[0]/det[0] pulse 1 cycle at the 6th edge after sampling; fall[0] pulses later.
//     -> det[0] stays 0 on the fall; cnt_out(sel=0)=1; sticky[0]=1.
//  2. Ch1 mode=11; d[1] toggles high for 3 cycles, then low.
//     -> No rise/fall/det (glitch < DEB_CYCLES), cnt=0.
//     Then high for 4 or more cycles -> one det pulse.
//  3. Ch2 mode=10; 3 full high/low cycles, each level held 8 cycles.
//     -> 3 det pulses on falls only, cnt=3.
//     clr[2] in the same cycle as the 3rd det -> sticky[2] stays 1.
//     Next cycle clr[2]=1 -> sticky[2]=0.
//  4. CNT_W=2, ch3 mode=01; 5 rising transitions -> cnt saturates at 3.
//     cnt_clr coincident with a det -> cnt=1.
//  5. d[4]=1 stable; pulse rst_n low mid-debounce for 1 cycle.
//     -> All outputs 0 immediately; after release, det[4] pulses once at normal latency.
//  6. SYNC_STAGES=3, DEB_CYCLES=1; all channels mode=11; d=8'hA5 then 8'h5A.
//     -> rise=8'hA5 after the 4th edge.
//     -> Second change: rise=8'h5A and fall=8'hA5 in the same cycle.
//     -> cnt_sel=7 reads 1.

Source files
------------

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector for asynchronous inputs: synchroniser, debounce
// filter, mode-masked event pulses, sticky flags and saturating event counters.
module multi_edge_detector #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int CNT_W       = 8,
  localparam int SEL_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   d,
  input  logic [2*WIDTH-1:0] mode,
  output logic [WIDTH-1:0]   det,
  output logic [WIDTH-1:0]   rise,
  output logic [WIDTH-1:0]   fall,
  output logic [WIDTH-1:0]   sticky,
  input  logic [WIDTH-1:0]   clr,
  input  logic               cnt_clr,
  input  logic [SEL_W-1:0]   cnt_sel,
  output logic [CNT_W-1:0]   cnt_out
);

  localparam int DC_W = $clog2(DEB_CYCLES) + 1;
  localparam logic [DC_W-1:0]  DC_LAST = DC_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] sync_p0 [SYNC_STAGES];
  logic [WIDTH-1:0] s_p0;
  logic [WIDTH-1:0] f_p1, f_next;
  logic [DC_W-1:0]  dc_p1 [WIDTH];
  logic [DC_W-1:0]  dc_next [WIDTH];
  logic [WIDTH-1:0] rise_next, fall_next, det_next, sticky_next;
  logic [CNT_W-1:0] cnt_p2 [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign s_p0 = sync_p0[SYNC_STAGES-1];

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      f_next[i]  = f_p1[i];
      dc_next[i] = '0;
      if (s_p0[i] != f_p1[i]) begin
        if (dc_p1[i] == DC_LAST) f_next[i] = s_p0[i];
        else                     dc_next[i] = dc_p1[i] + 1'b1;
      end
    end
    rise_next   = f_next & ~f_p1;
    fall_next   = ~f_next & f_p1;
    for (int i = 0; i < WIDTH; i++) begin
      det_next[i] = (rise_next[i] & mode[2*i]) | (fall_next[i] & mode[2*i+1]);
    end
    // A new event takes priority over a clear arriving on the same edge.
    sticky_next = det_next | (sticky & ~clr);
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_clr)          cnt_next[i] = CNT_W'(det_next[i]);
      else if (det_next[i]) cnt_next[i] = sat_inc(cnt_p2[i]);
      else                  cnt_next[i] = cnt_p2[i];
    end
  end

  // stage p0: synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_p0[k] <= '0;
    end else begin
      sync_p0[0] <= d;
      for (int k = 1; k < SYNC_STAGES; k++) sync_p0[k] <= sync_p0[k-1];
    end
  end

  // stage p1: debounce filter and registered event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_p1   <= '0;
      rise   <= '0;
      fall   <= '0;
      det    <= '0;
      sticky <= '0;
      for (int i = 0; i < WIDTH; i++) dc_p1[i] <= '0;
    end else begin
      f_p1   <= f_next;
      rise   <= rise_next;
      fall   <= fall_next;
      det    <= det_next;
      sticky <= sticky_next;
      for (int i = 0; i < WIDTH; i++) dc_p1[i] <= dc_next[i];
    end
  end

  // stage p2: event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) cnt_p2[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_p2[i] <= cnt_next[i];
    end
  end

  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_sel == SEL_W'(i)) cnt_out = cnt_p2[i];
    end
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector: default, narrow-counter and
// fast-filter instances driven with hand-computed expectations.
module tb_multi_edge_detector;

  logic        clk;
  logic        rst_n;

  logic [7:0]  d0, det0, rise0, fall0, sticky0, clr0;
  logic [15:0] mode0;
  logic        cnt_clr0;
  logic [2:0]  cnt_sel0;
  logic [7:0]  cnt_out0;

  logic [7:0]  d1, det1, rise1, fall1, sticky1, clr1;
  logic [15:0] mode1;
  logic        cnt_clr1;
  logic [2:0]  cnt_sel1;
  logic [1:0]  cnt_out1;

  logic [7:0]  d2, det2, rise2, fall2, sticky2, clr2;
  logic [15:0] mode2;
  logic        cnt_clr2;
  logic [2:0]  cnt_sel2;
  logic [7:0]  cnt_out2;

  int n_checks = 0;
  int n_errors = 0;

  multi_edge_detector u_def (
    .clk(clk), .rst_n(rst_n), .d(d0), .mode(mode0), .det(det0), .rise(rise0),
    .fall(fall0), .sticky(sticky0), .clr(clr0), .cnt_clr(cnt_clr0),
    .cnt_sel(cnt_sel0), .cnt_out(cnt_out0)
  );

  multi_edge_detector #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .d(d1), .mode(mode1), .det(det1), .rise(rise1),
    .fall(fall1), .sticky(sticky1), .clr(clr1), .cnt_clr(cnt_clr1),
    .cnt_sel(cnt_sel1), .cnt_out(cnt_out1)
  );

  multi_edge_detector #(.SYNC_STAGES(3), .DEB_CYCLES(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .d(d2), .mode(mode2), .det(det2), .rise(rise2),
    .fall(fall2), .sticky(sticky2), .clr(clr2), .cnt_clr(cnt_clr2),
    .cnt_sel(cnt_sel2), .cnt_out(cnt_out2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hits, ndet, nrise, nfall, exp_cnt;
    rst_n = 1'b0;
    d0 = '0; clr0 = '0; cnt_clr0 = 1'b0; cnt_sel0 = '0;
    d1 = '0; clr1 = '0; cnt_clr1 = 1'b0; cnt_sel1 = 3'd3;
    d2 = '0; clr2 = '0; cnt_clr2 = 1'b0; cnt_sel2 = 3'd7;
    mode0 = 16'h032D;  // ch0 rise, ch1 both, ch2 fall, ch4 both
    mode1 = 16'h0040;  // ch3 rise
    mode2 = 16'hFFFF;
    repeat (2) tick();
    check("rst_det", det0, 0);
    check("rst_rise", rise0, 0);
    check("rst_fall", fall0, 0);
    check("rst_sticky", sticky0, 0);
    check("rst_cnt", cnt_out0, 0);
    rst_n = 1'b1;
    tick();

    // Channel 0: rising edge detected, falling edge masked
    d0[0] = 1'b1;
    repeat (5) tick();
    check("t1_rise_early", rise0[0], 0);
    tick();
    check("t1_rise", rise0[0], 1);
    check("t1_det", det0[0], 1);
    tick();
    check("t1_rise_one_cycle", rise0[0], 0);
    check("t1_sticky", sticky0[0], 1);
    check("t1_cnt", cnt_out0, 1);
    repeat (3) tick();
    d0[0] = 1'b0;
    repeat (5) tick();
    check("t1_fall_early", fall0[0], 0);
    tick();
    check("t1_fall", fall0[0], 1);
    check("t1_det_masked", det0[0], 0);
    tick();
    check("t1_cnt_after_fall", cnt_out0, 1);

    // Channel 1: 3-cycle glitch rejected, then a held level accepted
    cnt_sel0 = 3'd1;
    d0[1] = 1'b1;
    repeat (3) tick();
    d0[1] = 1'b0;
    hits = 0;
    repeat (12) begin tick(); hits += int'(rise0[1] | fall0[1] | det0[1]); end
    check("t2_glitch_events", hits, 0);
    check("t2_glitch_cnt", cnt_out0, 0);
    d0[1] = 1'b1;
    hits = 0;
    repeat (12) begin tick(); hits += int'(det0[1]); end
    check("t2_held_det", hits, 1);
    check("t2_held_cnt", cnt_out0, 1);

    // Channel 2: falls only, sticky set beats clear, then clear
    cnt_sel0 = 3'd2;
    ndet = 0; nrise = 0;
    for (int r = 0; r < 3; r++) begin
      d0[2] = 1'b1;
      repeat (8) begin tick(); ndet += int'(det0[2]); nrise += int'(rise0[2]); end
      d0[2] = 1'b0;
      if (r < 2) begin
        repeat (8) begin tick(); ndet += int'(det0[2]); end
      end else begin
        repeat (5) begin tick(); ndet += int'(det0[2]); end
        clr0[2] = 1'b1;
        tick();
        ndet += int'(det0[2]);
        check("t3_det3", det0[2], 1);
        check("t3_sticky_set_wins", sticky0[2], 1);
        tick();
        check("t3_sticky_cleared", sticky0[2], 0);
        clr0[2] = 1'b0;
      end
    end
    check("t3_det_count", ndet, 3);
    check("t3_rise_count", nrise, 3);
    check("t3_cnt", cnt_out0, 3);

    // Channel 4: reset mid-debounce, event re-reported after release
    d0[4] = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("t5_rst_rise", rise0, 0);
    check("t5_rst_det", det0, 0);
    check("t5_rst_sticky", sticky0, 0);
    check("t5_rst_cnt", cnt_out0, 0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("t5_det_early", det0, 0);
    tick();
    check("t5_det", det0, 8'h12);
    tick();
    check("t5_det_one_cycle", det0, 0);
    check("t5_sticky", sticky0[4], 1);

    // Narrow counter instance: saturation and clear behaviour
    nrise = 0; nfall = 0;
    for (int k = 0; k < 5; k++) begin
      d1[3] = 1'b1;
      repeat (8) begin tick(); nrise += int'(rise1[3]); end
      d1[3] = 1'b0;
      repeat (8) begin tick(); nfall += int'(fall1[3]); end
      exp_cnt = (k + 1 > 3) ? 3 : k + 1;
      check($sformatf("t4_cnt_%0d", k), cnt_out1, exp_cnt);
    end
    check("t4_rise_count", nrise, 5);
    check("t4_fall_count", nfall, 5);
    check("t4_sticky", sticky1[3], 1);
    d1[3] = 1'b1;
    repeat (5) tick();
    cnt_clr1 = 1'b1;
    tick();
    cnt_clr1 = 1'b0;
    check("t4_clr_det", det1[3], 1);
    check("t4_clr_with_det", cnt_out1, 1);
    cnt_clr1 = 1'b1;
    tick();
    cnt_clr1 = 1'b0;
    check("t4_clr_no_det", cnt_out1, 0);

    // Fast instance: 3 sync stages, no filtering
    d2 = 8'hA5;
    repeat (3) tick();
    check("t6_rise_early", rise2, 0);
    tick();
    check("t6_rise1", rise2, 8'hA5);
    check("t6_det1", det2, 8'hA5);
    check("t6_fall1", fall2, 0);
    tick();
    check("t6_rise_one_cycle", rise2, 0);
    check("t6_cnt7_first", cnt_out2, 1);
    d2 = 8'h5A;
    repeat (4) tick();
    check("t6_rise2", rise2, 8'h5A);
    check("t6_fall2", fall2, 8'hA5);
    check("t6_det2", det2, 8'hFF);
    check("t6_cnt7_second", cnt_out2, 2);
    check("t6_sticky", sticky2, 8'hFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
